// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instr_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_fifo.sv
// In-order IR buffer: push/pop/flush with occupancy count and head output.
// Flush wins over push and pop; push on full is accepted only alongside a pop.
module instr_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_push_data,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_COUNT) || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: sequential fetch, credit-limited issue, stale-response kill.
// Optional FETCH_MISALIGN_CHECK_EN traps misaligned redirects into a FAULT state.
import instr_fetch_pkg::*;

module instr_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        fetch_fault,
    output logic [1:0]  dbg_state
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rsp_pc;
    logic [OW-1:0]     r_outstanding;
    logic [OW-1:0]     r_kill_cnt;
    logic              r_halted;
    logic              r_fault;
    logic [2*XLEN-1:0] r_last;

    logic [OW-1:0]     w_out_next;
    logic [2*XLEN-1:0] w_head;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_fifo_count;
    logic              w_accept;
    logic              w_rsp;
    logic              w_push;
    logic              w_pop;
    logic              w_credit;
    logic              w_misalign;
    logic [XLEN-1:0]   w_redir_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_redir_pc = redirect_pc;
    assign w_misalign = (redirect_pc[1:0] != 2'b00);
`else
    assign w_redir_pc = redirect_pc & ~32'h3;
    assign w_misalign = 1'b0;
`endif

    // Credit counts in-flight requests against free FIFO slots so no response is ever dropped.
    assign w_credit = (32'(r_outstanding) < 32'(MAX_OUTSTANDING)) &&
                      ((32'(r_outstanding) + 32'(w_fifo_count)) < 32'(FIFO_DEPTH));

    assign mem_req_valid = (r_state == RUN) && !halt_req && w_credit;
    assign mem_req_addr  = r_pc;
    assign w_accept      = mem_req_valid && mem_req_ready;
    assign w_rsp         = mem_rsp_valid && (r_outstanding != '0);
    assign w_push        = w_rsp && (r_kill_cnt == '0) && !redirect_valid;
    assign w_pop         = ir_valid && ir_ready;

    always_comb begin
        w_out_next = r_outstanding;
        case ({w_accept, w_rsp})
            2'b10:   w_out_next = r_outstanding + OW'(1);
            2'b01:   w_out_next = r_outstanding - OW'(1);
            default: w_out_next = r_outstanding;
        endcase
    end

    instr_fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .i_push_data ({mem_rsp_data, r_rsp_pc}),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_kill_cnt    <= '0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
            r_last        <= {NOP_INSTR, RESET_PC};
        end else begin
            r_outstanding <= w_out_next;
            if (!w_fifo_empty) begin
                r_last <= w_head;
            end
            // Everything still in flight after this cycle belongs to the old path.
            if (redirect_valid) begin
                r_pc       <= w_redir_pc;
                r_rsp_pc   <= w_redir_pc;
                r_kill_cnt <= w_out_next;
                r_halted   <= 1'b0;
                r_fault    <= w_misalign;
                r_state    <= w_misalign ? FAULT : RUN;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_rsp && (r_kill_cnt != '0)) begin
                    r_kill_cnt <= r_kill_cnt - OW'(1);
                end
                case (r_state)
                    BOOT: r_state <= RUN;
                    RUN: begin
                        if (halt_req && (r_outstanding == '0)) begin
                            r_state  <= HALT;
                            r_halted <= 1'b1;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign ir_valid    = !w_fifo_empty;
    assign ir          = w_fifo_empty ? r_last[2*XLEN-1:XLEN] : w_head[2*XLEN-1:XLEN];
    assign ir_pc       = w_fifo_empty ? r_last[XLEN-1:0]      : w_head[XLEN-1:0];
    assign halted      = r_halted;
    assign fetch_fault = r_fault;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model, expected-stream scoreboard, redirect table.
// Exercises FETCH_MISALIGN_CHECK_EN behaviour when that macro is defined for the build.
import instr_fetch_pkg::*;

module tb_instr_fetch;

    localparam int FIFO_DEPTH = 2;
    localparam int MAX_OUT    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        fetch_fault;
    logic [1:0]  dbg_state;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .ir_valid       (ir_valid),
        .ir_ready       (ir_ready),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted),
        .fetch_fault    (fetch_fault),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int accepts = 0;
    int pops    = 0;
    int first_acc_cyc = -1;
    int first_pop_cyc = -1;
    int rdy_pct = 100;
    int ird_pct = 100;
    int lat_min = 0;
    int lat_extra = 0;

    logic [31:0] req_exp;
    logic [31:0] exp_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [31:0] pop_log[$];

    typedef struct {
        logic [31:0] target;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F13;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt_req = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        ir_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir", ir, 32'h0000_0013);
        chk("rst_ir_pc", ir_pc, 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(BOOT));
        rst = 1'b0;
        mem_addr_q.delete();
        mem_due_q.delete();
        exp_q.delete();
        pop_log.delete();
        req_exp = 32'h0;
        accepts = 0;
        pops = 0;
        first_acc_cyc = -1;
        first_pop_cyc = -1;
    endtask

    // One clock cycle: drive inputs, observe the handshakes, advance to just after the edge.
    task automatic tick(input logic redir, input logic [31:0] rpc);
        logic rsp_now;
        redirect_valid = redir;
        redirect_pc = rpc;
        mem_req_ready = ($urandom_range(99) < rdy_pct);
        ir_ready = ($urandom_range(99) < ird_pct);
        rsp_now = (mem_addr_q.size() > 0) && (mem_due_q[0] <= cyc);
        mem_rsp_valid = rsp_now;
        mem_rsp_data = rsp_now ? mem_word(mem_addr_q[0]) : $urandom;
        #1;
        if (halt_req && mem_req_valid) fail_now("req_while_halt_req");
        if (ir_valid && ir_ready) begin
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            pop_log.push_back(ir_pc);
            if (exp_q.size() == 0) begin
                fail_now("ir_unexpected");
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("ir_pc", ir_pc, e);
                chk("ir_data", ir, mem_word(e));
            end
        end
        if (mem_req_valid && mem_req_ready) begin
            chk("req_addr", mem_req_addr, req_exp);
            accepts++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            mem_addr_q.push_back(req_exp);
            mem_due_q.push_back(cyc + 1 + lat_min + $urandom_range(lat_extra));
            if (!redir) exp_q.push_back(req_exp);
            req_exp = req_exp + 32'd4;
            if (mem_addr_q.size() > MAX_OUT) fail_now("outstanding_overflow");
        end
        if (rsp_now) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (redir) begin
            exp_q.delete();
            req_exp = rpc & ~32'h3;
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget);
        for (int i = 0; i < budget && pop_log.size() < n; i++) tick(1'b0, '0);
        if (pop_log.size() < n) fail_now("pop_timeout");
    endtask

    initial begin
        int acc0;
        logic [31:0] tgt;
        vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[2] = '{32'h0000_2000, 32'h0000_2000, 32'h0000_2004};
        vecs[3] = '{32'h7FFF_FFF8, 32'h7FFF_FFF8, 32'h7FFF_FFFC};
`ifdef FETCH_MISALIGN_CHECK_EN
        vecs[4] = '{32'h0000_3000, 32'h0000_3000, 32'h0000_3004};
`else
        vecs[4] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
`endif

        // Sequential fetch from reset, 1-cycle memory, decode always ready.
        do_reset();
        rdy_pct = 100; ird_pct = 100; lat_min = 0; lat_extra = 0;
        repeat (20) tick(1'b0, '0);
        chk("first_acc_cycle", 32'(first_acc_cyc), 32'd1);
        chk("fetch_latency", 32'(first_pop_cyc - first_acc_cyc), 32'd2);
        chk("seq_pops_nonzero", 32'(pops > 4), 32'd1);
        if (pop_log.size() > 0) chk("seq_last_pc", pop_log[$], 32'((pops - 1) * 4));

        // Decode stalled: only FIFO_DEPTH requests may go out.
        do_reset();
        ird_pct = 0;
        repeat (12) tick(1'b0, '0);
        chk("stall_accepts", 32'(accepts), 32'(FIFO_DEPTH));
        chk("stall_ir_valid", 32'(ir_valid), 32'd1);
        chk("stall_req_valid", 32'(mem_req_valid), 32'd0);
        chk("stall_head_pc", ir_pc, 32'h0);

        // Redirect with two requests in flight: both responses must vanish.
        do_reset();
        ird_pct = 0; lat_min = 4;
        for (int i = 0; i < 20 && mem_addr_q.size() < 2; i++) tick(1'b0, '0);
        chk("redir_outstanding", 32'(mem_addr_q.size()), 32'd2);
        tick(1'b1, 32'h0000_0100);
        pop_log.delete();
        ird_pct = 100;
        wait_pops(1, 40);
        if (pop_log.size() > 0) chk("redir_first_pc", pop_log[0], 32'h0000_0100);

        // Halt with one request outstanding, then resume by redirect.
        do_reset();
        lat_min = 3;
        for (int i = 0; i < 10 && accepts < 1; i++) tick(1'b0, '0);
        chk("halt_one_out", 32'(mem_addr_q.size()), 32'd1);
        halt_req = 1'b1;
        for (int i = 0; i < 20 && !halted; i++) tick(1'b0, '0);
        chk("halted_set", 32'(halted), 32'd1);
        chk("halted_drained", 32'(mem_addr_q.size()), 32'd0);
        chk("halt_state", 32'(dbg_state), 32'(HALT));
        halt_req = 1'b0;
        acc0 = accepts;
        repeat (3) tick(1'b0, '0);
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_no_issue", 32'(accepts), 32'(acc0));
        tick(1'b1, 32'h0000_0040);
        pop_log.delete();
        wait_pops(1, 30);
        if (pop_log.size() > 0) chk("resume_pc", pop_log[0], 32'h0000_0040);
        chk("resume_halted", 32'(halted), 32'd0);

        // Redirect table, including pc wrap past the top of the address space.
        lat_min = 0;
        for (int v = 0; v < 5; v++) begin
            tick(1'b1, vecs[v].target);
            pop_log.delete();
            wait_pops(2, 30);
            if (pop_log.size() >= 2) begin
                chk("vec_pc0", pop_log[0], vecs[v].pc0);
                chk("vec_pc1", pop_log[1], vecs[v].pc1);
            end
        end

        // Misaligned redirect.
        tick(1'b1, 32'h0000_0102);
        pop_log.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
        repeat (2) tick(1'b0, '0);
        chk("fault_set", 32'(fetch_fault), 32'd1);
        chk("fault_state", 32'(dbg_state), 32'(FAULT));
        acc0 = accepts;
        repeat (5) tick(1'b0, '0);
        chk("fault_no_issue", 32'(accepts), 32'(acc0));
        tick(1'b1, 32'h0000_0200);
        chk("fault_clear", 32'(fetch_fault), 32'd0);
        pop_log.delete();
        wait_pops(1, 30);
        if (pop_log.size() > 0) chk("fault_resume_pc", pop_log[0], 32'h0000_0200);
`else
        chk("no_fault", 32'(fetch_fault), 32'd0);
        wait_pops(1, 30);
        if (pop_log.size() > 0) chk("mask_pc", pop_log[0], 32'h0000_0100);
`endif

        // Random traffic with occasional redirects, then drain.
        do_reset();
        rdy_pct = 70; ird_pct = 60; lat_min = 0; lat_extra = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 3) begin
                tgt = ($urandom_range(1) == 0) ? ($urandom & ~32'h3)
                                               : (32'hFFFF_FFF0 + 32'($urandom_range(3)) * 4);
                tick(1'b1, tgt);
            end else begin
                tick(1'b0, '0);
            end
        end
        rdy_pct = 0; ird_pct = 100;
        repeat (30) tick(1'b0, '0);
        chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_mem_empty", 32'(mem_addr_q.size()), 32'd0);
        chk("drain_ir_valid", 32'(ir_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
